// File: rtl/boot_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boot_loader_pkg
//  Description : Shared types and constants for the UART boot loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package boot_loader_pkg;

    localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;
    localparam int         IMEM_ADDR_W    = 8;

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERR    = 3'd6
    } boot_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_DONE  = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/boot_loader_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with input synchronizer, mid-bit start
//                re-check and single stop-bit sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int                  c_cnt_w    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0]  c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0]  c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

    logic               r_sync1;
    logic               r_sync2;
    rx_state_t          r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_stop;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_stop      <= 1'b1;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (!r_sync2) begin
                        r_state <= RX_START;
                    end
                end
                // A low pulse that has gone by mid-bit is treated as noise.
                RX_START: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_stop  <= r_sync2;
                        r_state <= RX_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DONE: begin
                    r_data      <= r_shift;
                    r_frame_err <= ~r_stop;
                    r_valid     <= 1'b1;
                    r_state     <= RX_IDLE;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : boot_loader
//  Description : UART boot loader; streams a program image into IMEM and
//                releases the core reset. Optional trailing XOR checksum is
//                enabled with the BOOT_CHECKSUM_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int IMEM_DEPTH   = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   uart_rx_i,
    output logic                   imem_we_o,
    output logic [IMEM_ADDR_W-1:0] imem_addr_o,
    output logic [31:0]            imem_data_o,
    output logic                   core_rst_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam logic [16:0] c_depth = 17'(IMEM_DEPTH);

    logic [7:0]  w_rx_data;
    logic        w_rx_valid;
    logic        w_rx_frame_err;
    logic [16:0] w_len;

    boot_state_t          r_state;
    logic [15:0]          r_len;
    logic [15:0]          r_word_idx;
    logic [1:0]           r_byte_idx;
    logic [31:0]          r_asm;
    logic                 r_we;
    logic [IMEM_ADDR_W-1:0] r_addr;
    logic [31:0]          r_data;
    logic                 r_core_rst;
    logic                 r_done;
    logic                 r_err;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]           r_csum;
`endif

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (uart_rx_i),
        .rx_data      (w_rx_data),
        .rx_valid     (w_rx_valid),
        .rx_frame_err (w_rx_frame_err)
    );

    assign w_len = {1'b0, w_rx_data, r_len[7:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_SYNC;
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_SYNC: begin
                    if (w_rx_valid && !w_rx_frame_err && w_rx_data == BOOT_SYNC_BYTE) begin
                        r_state <= ST_LEN_LO;
`ifdef BOOT_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                ST_LEN_LO: begin
                    if (w_rx_valid) begin
                        if (w_rx_frame_err) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_len[7:0] <= w_rx_data;
                            r_state    <= ST_LEN_HI;
                        end
                    end
                end
                ST_LEN_HI: begin
                    if (w_rx_valid) begin
                        r_len[15:8] <= w_rx_data;
                        r_word_idx  <= '0;
                        r_byte_idx  <= '0;
                        if (w_rx_frame_err || w_len > c_depth) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end else if (w_len == 17'd0) begin
`ifdef BOOT_CHECKSUM_EN
                            r_state    <= ST_CSUM;
`else
                            r_state    <= ST_RUN;
                            r_core_rst <= 1'b0;
                            r_done     <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                // The exit check waits for the write pulse so RUN follows it by one cycle.
                ST_DATA: begin
                    if (r_we && r_word_idx == r_len) begin
`ifdef BOOT_CHECKSUM_EN
                        r_state    <= ST_CSUM;
`else
                        r_state    <= ST_RUN;
                        r_core_rst <= 1'b0;
                        r_done     <= 1'b1;
`endif
                    end else if (w_rx_valid) begin
                        if (w_rx_frame_err) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_asm      <= {w_rx_data, r_asm[31:8]};
                            r_byte_idx <= r_byte_idx + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                            r_csum     <= r_csum ^ w_rx_data;
`endif
                            if (r_byte_idx == 2'd3) begin
                                r_we       <= 1'b1;
                                r_addr     <= r_word_idx[IMEM_ADDR_W-1:0];
                                r_data     <= {w_rx_data, r_asm[31:8]};
                                r_word_idx <= r_word_idx + 16'd1;
                            end
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_rx_valid) begin
                        if (w_rx_frame_err || w_rx_data != r_csum) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state    <= ST_RUN;
                            r_core_rst <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
`endif
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_ERR;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    assign imem_we_o   = r_we;
    assign imem_addr_o = r_addr;
    assign imem_data_o = r_data;
    assign core_rst_o  = r_core_rst;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boot_loader
//  Description : Directed self-checking bench for boot_loader (CLKS_PER_BIT=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

    localparam int c_cpb = 8;

    logic        clk;
    logic        rst;
    logic        uart_rx;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        core_rst;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    // write log and timing markers, owned by the monitor only
    logic [7:0]  wa [64];
    logic [31:0] wd [64];
    int          wr_n      = 0;
    int          cyc       = 0;
    int          last_we   = -1;
    int          done_rise = -1;
    logic        prev_done = 1'b0;

    boot_loader #(
        .CLKS_PER_BIT (c_cpb),
        .IMEM_DEPTH   (256)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .uart_rx_i   (uart_rx),
        .imem_we_o   (imem_we),
        .imem_addr_o (imem_addr),
        .imem_data_o (imem_data),
        .core_rst_o  (core_rst),
        .done_o      (done),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (imem_we) begin
            if (wr_n < 64) begin
                wa[wr_n] = imem_addr;
                wd[wr_n] = imem_data;
            end
            wr_n    = wr_n + 1;
            last_we = cyc;
        end
        if (done && !prev_done) done_rise = cyc;
        prev_done = done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) uart_rx = 1'b0;
        repeat (c_cpb - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) uart_rx = b[i];
            repeat (c_cpb - 1) @(negedge clk);
        end
        @(negedge clk) uart_rx = stop_bit;
        repeat (c_cpb - 1) @(negedge clk);
        @(negedge clk) uart_rx = 1'b1;
        repeat (2 * c_cpb) @(negedge clk);
    endtask

    task automatic send_normal_image(input logic [7:0] csum);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h6F, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
`ifdef BOOT_CHECKSUM_EN
        send_byte(csum, 1'b1);
`else
        if (csum != 8'h00) repeat (1) @(negedge clk);
`endif
        repeat (40) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int base;

    initial begin
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);

        // reset state, sampled while reset is held
        check("rst_we",       {31'b0, imem_we}, 32'd0);
        check("rst_addr",     {24'b0, imem_addr}, 32'd0);
        check("rst_data",     imem_data, 32'd0);
        check("rst_core_rst", {31'b0, core_rst}, 32'd1);
        check("rst_done",     {31'b0, done}, 32'd0);
        check("rst_err",      {31'b0, err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // normal two-word load
        base = wr_n;
        send_normal_image(8'h7C);
        check("norm_writes", wr_n - base, 32'd2);
        check("norm_addr0",  {24'b0, wa[base]}, 32'd0);
        check("norm_data0",  wd[base], 32'h0000_0013);
        check("norm_addr1",  {24'b0, wa[base+1]}, 32'd1);
        check("norm_data1",  wd[base+1], 32'h0000_006F);
        check("norm_done",   {31'b0, done}, 32'd1);
        check("norm_core_rst", {31'b0, core_rst}, 32'd0);
        check("norm_err",    {31'b0, err}, 32'd0);
`ifdef BOOT_CHECKSUM_EN
        check("norm_run_after_csum", {31'b0, (done_rise > last_we + 1)}, 32'd1);
`else
        check("norm_run_timing", done_rise, last_we + 1);
`endif
        // bytes after RUN are ignored
        base = wr_n;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (20) @(negedge clk);
        check("run_ignore_writes", wr_n - base, 32'd0);
        check("run_ignore_done", {31'b0, done}, 32'd1);

        // garbage before sync, then an empty image
        do_reset();
        check("post_rst_done", {31'b0, done}, 32'd0);
        base = wr_n;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h00, 1'b1);
`endif
        repeat (30) @(negedge clk);
        check("empty_writes", wr_n - base, 32'd0);
        check("empty_done",   {31'b0, done}, 32'd1);
        check("empty_core_rst", {31'b0, core_rst}, 32'd0);
        check("empty_err",    {31'b0, err}, 32'd0);

        // oversize word count 257
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (30) @(negedge clk);
        check("over_err",      {31'b0, err}, 32'd1);
        check("over_core_rst", {31'b0, core_rst}, 32'd1);
        check("over_done",     {31'b0, done}, 32'd0);
        check("over_writes",   wr_n - base, 32'd0);

        // exactly IMEM_DEPTH words is accepted as a length
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (30) @(negedge clk);
        check("depth_ok_err", {31'b0, err}, 32'd0);

        // framing error on the 2nd data byte
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (30) @(negedge clk);
        check("frame_err",      {31'b0, err}, 32'd1);
        check("frame_core_rst", {31'b0, core_rst}, 32'd1);
        check("frame_writes",   wr_n - base, 32'd0);

        // framing error while hunting for sync is dropped silently
        do_reset();
        send_byte(8'hA5, 1'b0);
        repeat (30) @(negedge clk);
        check("sync_frame_err", {31'b0, err}, 32'd0);

`ifdef BOOT_CHECKSUM_EN
        // wrong checksum
        do_reset();
        base = wr_n;
        send_normal_image(8'h00);
        check("csum_err",    {31'b0, err}, 32'd1);
        check("csum_done",   {31'b0, done}, 32'd0);
        check("csum_writes", wr_n - base, 32'd2);
`endif

        // reset after 5 data bytes, then a full reload
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h6F, 1'b1);
        check("abort_partial_writes", wr_n - base, 32'd1);
        do_reset();
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_core_rst", {31'b0, core_rst}, 32'd1);
        base = wr_n;
        send_normal_image(8'h7C);
        check("reload_writes", wr_n - base, 32'd2);
        check("reload_addr0",  {24'b0, wa[base]}, 32'd0);
        check("reload_data0",  wd[base], 32'h0000_0013);
        check("reload_addr1",  {24'b0, wa[base+1]}, 32'd1);
        check("reload_data1",  wd[base+1], 32'h0000_006F);
        check("reload_done",   {31'b0, done}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/boot_loader.md
# boot_loader

UART boot loader that fills the instruction memory before the RISC-V core runs. It sits upstream of the core/IMEM pair and holds the core in reset while a host streams a program image over a serial line. It writes each assembled 32-bit word into IMEM through a single-cycle write port, then releases the core reset. Load and framing failures park the block in an error state until the next reset.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200).
- `IMEM_DEPTH`, default 256: IMEM size in 32-bit words; the maximum accepted word count.
- `clk_i`, in, 1: system clock; the block's only clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `uart_rx_i`, in, 1: serial input, 8N1, LSB first, idle high; asynchronous to `clk_i`.
- `imem_we_o`, out, 1: IMEM write strobe, one-cycle pulse per word.
- `imem_addr_o`, out, 8: IMEM word address (byte address >> 2).
- `imem_data_o`, out, 32: IMEM write data, valid while `imem_we_o`=1.
- `core_rst_o`, out, 1: active-high reset to `rv_core`; high until the load completes.
- `done_o`, out, 1: load completed; core running.
- `err_o`, out, 1: load failed; sticky until `rst_i`.

## Operation
- Wire protocol, in order:
  - sync byte 0xA5
  - word count N as 2 bytes, little-endian
  - N words, each 4 bytes little-endian
  - optional checksum byte (see Configuration)
- FSM states: `SYNC`, `LEN_LO`, `LEN_HI`, `DATA`, `CSUM`, `RUN`, `ERR`.
  - `SYNC`: bytes other than 0xA5 are discarded; on 0xA5 go to `LEN_LO`.
  - `LEN_LO` → `LEN_HI`: latch N.
  - After `LEN_HI`: if N > IMEM_DEPTH → `ERR`. If N = 0 → `CSUM` (or `RUN` if checksum disabled). Otherwise → `DATA`.
  - `DATA`: a 2-bit byte index shifts bytes into a 32-bit assembly register. On the 4th byte, pulse `imem_we_o` with `imem_addr_o` = word index, then increment the word index. After word N → `CSUM`/`RUN`.
  - `RUN`: terminal; `core_rst_o`=0, `done_o`=1. Further UART bytes are ignored.
  - `ERR`: terminal; `err_o`=1, `core_rst_o` stays 1.
- Word index is 16 bits internally; `imem_addr_o` is its low 8 bits. No wrap-around is possible because N ≤ IMEM_DEPTH is enforced.
- UART receiver:
  - two-flop synchronizer on `uart_rx_i`
  - start bit re-checked at mid-bit (CLKS_PER_BIT/2); a glitch shorter than that returns the receiver to idle with no byte
  - data sampled at bit centres
  - stop bit sampled once
- Stop bit = 0 is a framing error:
  - in `SYNC`, the byte is dropped silently
  - in any other loading state, go to `ERR`
- `rst_i` asserted mid-load aborts immediately. All state returns to reset values and IMEM contents written so far are left as-is; the host restarts from the sync byte.

## Timing
- Reset values: `imem_we_o`=0, `imem_addr_o`=0, `imem_data_o`=0, `core_rst_o`=1, `done_o`=0, `err_o`=0.
- Receiver asserts a one-cycle `rx_valid` 1 cycle after sampling the stop bit.
- `imem_we_o` asserts the cycle after `rx_valid` of the word's 4th byte.
  - `imem_addr_o`/`imem_data_o` are stable in that cycle; IMEM captures on the same edge.
- Entering `RUN`: `core_rst_o` falls and `done_o` rises on the same edge that enters `RUN`. That edge is the cycle after the last `imem_we_o` pulse, or after the checksum byte's `rx_valid`.
- Entering `ERR`: `err_o` rises on the edge that enters `ERR`.
- All outputs are registered.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - after the data, one checksum byte follows, equal to the XOR of all N×4 data bytes
  - match → `RUN`; mismatch → `ERR`
  - the running XOR register is reset on entry to `LEN_LO`
- `BOOT_CHECKSUM_EN` undefined:
  - `CSUM` state and XOR logic are absent
  - after the last word (or N=0) go straight to `RUN`

## Structure
- Shared package/header holds the FSM state encodings, the sync byte constant `BOOT_SYNC_BYTE` = 8'hA5, and the IMEM address width (8).
- Sub-module `uart_rx` contains the synchronizer, bit counter, baud counter and start/stop checks. Its outputs are `rx_data[7:0]`, `rx_valid` and `rx_frame_err`.
- The top level holds the FSM, assembly register, word counter and checksum.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- Reset: hold `rst_i`=1 → all outputs at reset values; `core_rst_o`=1.
- Normal load:
  - stimulus: A5, 02 00, 13 00 00 00, 6F 00 00 00 (+ checksum 7C if `BOOT_CHECKSUM_EN`)
  - response: `imem_we_o` pulses with (0, 0x00000013) then (1, 0x0000006F)
  - then `core_rst_o`=0 and `done_o`=1, one cycle after the last write (or after the checksum byte's `rx_valid` when `BOOT_CHECKSUM_EN` is defined)
- Garbage before sync, then empty image: bytes 00 FF 3C, then A5 00 00 (+ checksum 00) → no writes; `done_o`=1.
- Oversize: A5 01 01 (N=257 > 256) → `err_o`=1, `core_rst_o`=1, no `imem_we_o`.
- Faults:
  - stop bit forced to 0 on the 2nd data byte → `err_o`=1
  - with `BOOT_CHECKSUM_EN`, checksum 00 instead of 7C → `err_o`=1, `done_o`=0
- Reset mid-load: assert `rst_i` after 5 data bytes, release, then send the full normal image → both words written from address 0; `done_o`=1.
